// File: rtl/param_acc_register_bank_pkg.sv
// Shared definitions for the accumulating register bank.
// Holds the MODE write-operation encodings and the drain FSM state type.
package param_acc_register_bank_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_ACC  = 2'b10;
  localparam logic [1:0] MODE_CLR  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/param_acc_register_bank_entry.sv
// acc_reg_entry: one WIDTH-bit storage entry plus its sticky saturation bit.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset (clears value and sat)
//   en    - write command for this entry this cycle
//   mode  - hold / load / accumulate / clear-entry
//   d     - write data
//   value - stored entry
//   sat   - sticky saturation flag, cleared only by clear-entry or reset
module acc_reg_entry
  import param_acc_register_bank_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] value,
  output logic             sat
);

  // Unsigned add with clamp to all-ones; MSB of the result flags overflow.
  function automatic logic [WIDTH:0] sat_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[WIDTH]) sat_add = {1'b1, {WIDTH{1'b1}}};
    else            sat_add = {1'b0, sum[WIDTH-1:0]};
  endfunction

  logic [WIDTH:0] acc_res;
  assign acc_res = sat_add(value, d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
      sat   <= 1'b0;
    end else if (en) begin
      case (mode)
        MODE_LOAD: value <= d;   // load keeps the sticky flag
        MODE_ACC: begin
          value <= acc_res[WIDTH-1:0];
          sat   <= sat | acc_res[WIDTH];
        end
        MODE_CLR: begin
          value <= '0;
          sat   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/param_acc_register_bank.sv
// Parameterised bank of DEPTH accumulating registers with a combinational
// tri-state read port and an OE-paced drain that streams every entry out in
// address order.
// Ports:
//   Clk, MR    - clock and asynchronous active-low master reset
//   L, MODE    - write command enable and operation (hold/load/acc/clear)
//   WA, D      - write address and data
//   RA, OE     - idle read address; output enable (also drain advance)
//   DRAIN      - start a drain from entry 0
//   Q          - read data, high-Z whenever OE=0
//   DV, DONE   - drain word valid; last drained word
//   BUSY       - drain in progress (writes and new drains are dropped)
//   SAT        - OR of all per-entry sticky saturation bits
module param_acc_register_bank
  import param_acc_register_bank_pkg::*;
#(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             MR,
  input  logic             L,
  input  logic [1:0]       MODE,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    RA,
  input  logic             OE,
  input  logic             DRAIN,
  output wire  [WIDTH-1:0] Q,
  output logic             DV,
  output logic             DONE,
  output logic             BUSY,
  output logic             SAT
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t            state;
  logic [AW-1:0]     ptr;
  logic              wr_en;
  logic              last;
  logic [AW-1:0]     rd_idx;
  logic [WIDTH-1:0]  q_data;
  logic [WIDTH-1:0]  entry [DEPTH];
  logic [DEPTH-1:0]  sat_bits;

  assign BUSY  = (state == ST_DRAIN);
  assign wr_en = L && !BUSY && ({1'b0, WA} < DEPTH_W);
  assign last  = (ptr == LAST);
  assign DV    = BUSY && OE;
  assign DONE  = DV && last;
  assign SAT   = |sat_bits;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    acc_reg_entry #(.WIDTH(WIDTH)) u_entry (
      .clk   (Clk),
      .rst_n (MR),
      .en    (wr_en && (WA == AW'(i))),
      .mode  (MODE),
      .d     (D),
      .value (entry[i]),
      .sat   (sat_bits[i])
    );
  end

  // During a drain the pointer owns the read port and RA is ignored.
  always_comb begin
    rd_idx = BUSY ? ptr : RA;
    q_data = '0;
    if ({1'b0, rd_idx} < DEPTH_W) q_data = entry[rd_idx];
  end

  assign Q = OE ? q_data : {WIDTH{1'bz}};

  // Drain sequencer: ptr only advances on cycles where the word was taken.
  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (DRAIN) begin
            state <= ST_DRAIN;
            ptr   <= '0;
          end
        end
        ST_DRAIN: begin
          if (OE) begin
            if (last) begin
              state <= ST_IDLE;
              ptr   <= '0;
            end else begin
              ptr <= ptr + AW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_acc_register_bank.sv
module tb_param_acc_register_bank;
  import param_acc_register_bank_pkg::*;

  localparam int WIDTH = 10;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             Clk = 1'b0;
  logic             MR, L, OE, DRAIN;
  logic [1:0]       MODE;
  logic [AW-1:0]    WA, RA;
  logic [WIDTH-1:0] D;
  wire  [WIDTH-1:0] q_w;
  logic             DV, DONE, BUSY, SAT;

  always #5 Clk = ~Clk;

  param_acc_register_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .MR(MR), .L(L), .MODE(MODE), .WA(WA), .D(D), .RA(RA),
    .OE(OE), .DRAIN(DRAIN), .Q(q_w), .DV(DV), .DONE(DONE), .BUSY(BUSY), .SAT(SAT)
  );

  typedef struct {
    bit oe;
    int q;
    bit dv, done, busy, sat;
    int n;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   step_no = 0;

  // Reference model: plain arrays and a drain cursor.
  int m_mem [DEPTH];
  bit m_sat [DEPTH];
  bit m_busy;
  int m_ptr;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 0;
      m_sat[i] = 0;
    end
    m_busy = 0;
    m_ptr  = 0;
  endfunction

  function automatic bit model_sat_any();
    bit s = 0;
    for (int i = 0; i < DEPTH; i++) s |= m_sat[i];
    return s;
  endfunction

  task automatic chk(input string name, input int n, input bit ok, input int got, input int want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s step=%0d got=%0d want=%0d", name, n, got, want);
    end
  endtask

  // One clock cycle: drive inputs, predict outputs, advance model on the edge.
  task automatic step(input bit mr, input bit l, input bit [1:0] mode, input int wa,
                      input int d, input int ra, input bit oe, input bit drain);
    exp_t e;
    bit   was_busy;
    int   s;
    MR = mr; L = l; MODE = mode; WA = AW'(wa); D = WIDTH'(d); RA = AW'(ra);
    OE = oe; DRAIN = drain;
    if (!mr) model_reset();
    e.oe   = oe;
    e.busy = m_busy;
    e.dv   = m_busy && oe;
    e.done = e.dv && (m_ptr == DEPTH - 1);
    e.sat  = model_sat_any();
    if (m_busy)         e.q = m_mem[m_ptr];
    else if (ra < DEPTH) e.q = m_mem[ra];
    else                e.q = 0;
    e.n = step_no;
    step_no++;
    exp_q.push_back(e);
    @(posedge Clk);
    if (mr) begin
      was_busy = m_busy;
      if (!was_busy && l && wa < DEPTH) begin
        case (mode)
          MODE_LOAD: m_mem[wa] = d;
          MODE_ACC: begin
            s = m_mem[wa] + d;
            if (s > MAXV) begin
              m_mem[wa] = MAXV;
              m_sat[wa] = 1;
            end else begin
              m_mem[wa] = s;
            end
          end
          MODE_CLR: begin
            m_mem[wa] = 0;
            m_sat[wa] = 0;
          end
          default: ;
        endcase
      end
      if (!was_busy) begin
        if (drain) begin
          m_busy = 1;
          m_ptr  = 0;
        end
      end else if (oe) begin
        if (m_ptr == DEPTH - 1) begin
          m_busy = 0;
          m_ptr  = 0;
        end else begin
          m_ptr++;
        end
      end
    end
    #1;
  endtask

  // Monitor: every presented cycle is compared against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.oe) chk("q", e.n, q_w === WIDTH'(e.q), int'(q_w), e.q);
        else      chk("q_hiz", e.n, q_w === {WIDTH{1'bz}}, int'(q_w), 0);
        chk("dv",   e.n, DV   === e.dv,   int'(DV),   int'(e.dv));
        chk("done", e.n, DONE === e.done, int'(DONE), int'(e.done));
        chk("busy", e.n, BUSY === e.busy, int'(BUSY), int'(e.busy));
        chk("sat",  e.n, SAT  === e.sat,  int'(SAT),  int'(e.sat));
      end
    end
  end

  task automatic load_all(input int base);
    for (int i = 0; i < DEPTH; i++) step(1, 1, MODE_LOAD, i, base + i, 0, 0, 0);
  endtask

  initial begin
    MR = 0; L = 0; MODE = MODE_HOLD; WA = '0; D = '0; RA = '0; OE = 0; DRAIN = 0;
    model_reset();
    @(posedge Clk);
    #1;
    // reset state, with OE low and high
    step(0, 0, MODE_HOLD, 0, 0, 0, 0, 0);
    step(0, 0, MODE_HOLD, 0, 0, 2, 1, 0);
    // load / read / high-Z
    step(1, 1, MODE_LOAD, 2, 100, 0, 0, 0);
    step(1, 0, MODE_HOLD, 0, 0, 2, 1, 0);
    step(1, 0, MODE_HOLD, 0, 0, 2, 0, 0);
    // read and write same address: pre-edge value, new value next cycle
    step(1, 1, MODE_LOAD, 2, 55, 2, 1, 0);
    step(1, 0, MODE_HOLD, 0, 0, 2, 1, 0);
    // saturation, sticky across load, cleared by clear-entry
    step(1, 1, MODE_LOAD, 1, 1000, 1, 1, 0);
    step(1, 1, MODE_ACC, 1, 100, 1, 1, 0);
    step(1, 0, MODE_HOLD, 0, 0, 1, 1, 0);
    step(1, 1, MODE_LOAD, 1, 3, 1, 1, 0);
    step(1, 1, MODE_ACC, 1, 4, 1, 1, 0);
    step(1, 1, MODE_CLR, 1, 0, 1, 1, 0);
    step(1, 0, MODE_HOLD, 0, 0, 1, 1, 0);
    // full drain
    load_all(5);
    step(1, 0, MODE_HOLD, 0, 0, 0, 0, 1);
    repeat (4) step(1, 0, MODE_HOLD, 0, 0, 3, 1, 0);
    step(1, 0, MODE_HOLD, 0, 0, 0, 1, 0);
    // drain with a two-cycle OE stall after the second word
    step(1, 0, MODE_HOLD, 0, 0, 0, 0, 1);
    repeat (2) step(1, 0, MODE_HOLD, 0, 0, 0, 1, 0);
    repeat (2) step(1, 0, MODE_HOLD, 0, 0, 0, 0, 0);
    repeat (2) step(1, 0, MODE_HOLD, 0, 0, 0, 1, 0);
    step(1, 0, MODE_HOLD, 0, 0, 1, 1, 0);
    // reset mid-drain, then a normal write
    step(1, 0, MODE_HOLD, 0, 0, 0, 0, 1);
    repeat (2) step(1, 0, MODE_HOLD, 0, 0, 0, 1, 0);
    step(0, 0, MODE_HOLD, 0, 0, 0, 1, 0);
    step(1, 1, MODE_LOAD, 3, 77, 3, 1, 0);
    step(1, 0, MODE_HOLD, 0, 0, 3, 1, 0);
    // writes and DRAIN during a drain are dropped
    load_all(5);
    step(1, 0, MODE_HOLD, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 1, MODE_LOAD, i, 999, 0, 1, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 0, MODE_HOLD, 0, 0, i, 1, 0);
    // write and drain start in the same cycle
    step(1, 1, MODE_LOAD, 0, 321, 0, 0, 1);
    repeat (4) step(1, 0, MODE_HOLD, 0, 0, 0, 1, 0);
    step(1, 0, MODE_HOLD, 0, 0, 0, 1, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int d;
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(900, MAXV) : $urandom_range(0, MAXV);
      step(($urandom_range(0, 99) != 0), $urandom_range(0, 1), 2'($urandom_range(0, 3)),
           $urandom_range(0, DEPTH - 1), d, $urandom_range(0, DEPTH - 1),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
    end
    step(1, 0, MODE_HOLD, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue got=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
